tone_source: RTL
================

TONE_SOURCE -- requirements
Module: tone_source

Interface
REQ-001 The block SHALL have parameter SAMPLE_DIV, default 562, the number of clock cycles per audio sample; legal range 2..4095.
REQ-002 The block SHALL have parameter HOLD_SAMPLES, default 4800, the number of samples spent in HOLD; legal range 1..65535.
REQ-003 Port clock  input  1  is the single system clock; all logic is rising-edge.
REQ-004 Port reset  input  1  is the synchronous, active-high reset.
REQ-005 Port start  input  1  is a one-cycle request to begin a tone burst.
REQ-006 Port period  input  10  is the square-wave half-period, in samples, sampled on accepted start.
REQ-007 Port amplitude  input  17  is the unsigned peak magnitude, sampled on accepted start.
REQ-008 Port ready  output  1  is a one-cycle strobe marking a new sample on a_data.
REQ-009 Port a_data  output  18  is the signed two's-complement sample, bit 17 = sign; it is held constant between strobes.
REQ-010 Port busy  output  1  is high whenever the envelope FSM is not IDLE.

Function
REQ-011 A divider counter SHALL count 0..SAMPLE_DIV-1, wrap to 0, and assert ready for exactly one cycle on each wrap, in every FSM state, at a fixed rate of one strobe per SAMPLE_DIV clocks.
REQ-012 The FSM SHALL have states IDLE, ATTACK, HOLD and DECAY, with a 5-bit envelope env in 0..16.
REQ-013 In IDLE, a start pulse SHALL be accepted: it latches period and amplitude, clears the phase counter and polarity (positive), sets env=0, and moves the FSM to ATTACK on the next edge.
REQ-014 A start pulse while busy=1 SHALL be ignored, with no change to the latched values, state or phase.
REQ-015 All envelope and phase updates SHALL occur only on sample ticks, i.e. the edge on which ready is asserted.
REQ-016 In ATTACK, each tick SHALL increment env; the tick that makes env=16 moves the FSM to HOLD and clears the hold counter.
REQ-017 In HOLD, env SHALL stay at 16; after HOLD_SAMPLES ticks the FSM moves to DECAY.
REQ-018 In DECAY, each tick SHALL decrement env; the tick that makes env=0 moves the FSM to IDLE.
REQ-019 The phase counter SHALL count ticks 0..P-1 and toggle polarity on wrap, where P = latched period, with period==0 treated as P=1 (toggle every tick).
REQ-020 Magnitude SHALL be computed as mag = (amplitude * env) >> 4 using a full-width 22-bit product, so mag <= amplitude and mag never overflows 17 bits.
REQ-021 On each tick, a_data SHALL be loaded on the same edge that asserts ready with +mag (polarity positive) or -mag (negative), sign-extended to 18 bits, where mag, env and polarity are the values before that edge.
REQ-022 In IDLE, a_data SHALL be 18'd0 on every tick.
REQ-023 Zero magnitude SHALL always be emitted as 18'd0, never as a negative zero.
REQ-024 busy SHALL be asserted on the edge that leaves IDLE and deasserted on the edge that enters IDLE.

Reset
REQ-025 While reset is high, the block SHALL clear the divider to 0, the FSM to IDLE, env, the phase counter, polarity and the hold counter to 0, and drive ready=0, a_data=0, busy=0.
REQ-026 Reset asserted mid-burst SHALL abort the burst immediately, with no decay.
REQ-027 After reset deasserts, the first ready strobe SHALL occur SAMPLE_DIV cycles later.
REQ-028 Reset SHALL take priority over a start pulse in the same cycle.

Verification
REQ-029 Bench 1 (SAMPLE_DIV=4, idle, no start): ready pulses every 4 clocks, a_data=0, busy=0.
REQ-030 Bench 2 (SAMPLE_DIV=4, HOLD_SAMPLES=3): start with period=2, amplitude=1600 gives tick-by-tick a_data 0,+100,-200,-300,+400,..., reaching +/-1600 in HOLD for 3 ticks, then decreasing to 0, after which busy falls.
REQ-031 Bench 3: start with amplitude=131071, env=16 -> a_data=+131071 and -131071 (18'h20001) only, with no wrap.
REQ-032 Bench 4: a second start during HOLD with a different period and amplitude leaves the waveform and burst length unchanged.
REQ-033 Bench 5: reset asserted during ATTACK (env=5) gives a_data=0, busy=0 next cycle, and the first ready strobe SAMPLE_DIV cycles after reset release.
REQ-034 Bench 6: period=0 with amplitude=16 gives polarity alternating every tick: 0,-1,+2,-3,... during ATTACK.

Source files
------------

// File: rtl/tone_source.sv
// Square-wave tone burst generator with attack/hold/decay envelope, one sample per SAMPLE_DIV clocks.
// Latency: a_data and ready update on the same edge as the divider wrap; start is taken on the next edge.
// Backpressure: none; ready is a free-running strobe and start is ignored while a burst is active.
module tone_source #(
   parameter int SAMPLE_DIV   = 562,
   parameter int HOLD_SAMPLES = 4800
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [9:0]  period,
   input  logic [16:0] amplitude,
   output logic        ready,
   output logic [17:0] a_data,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, ATTACK, HOLD, DECAY} state_t;

   localparam logic [11:0] DIV_LAST  = 12'(SAMPLE_DIV - 1);
   localparam logic [15:0] HOLD_LAST = 16'(HOLD_SAMPLES - 1);

   state_t      state_q, state_d;
   logic [11:0] div_q, div_d;
   logic        ready_q, ready_d;
   logic [4:0]  env_q, env_d;
   logic [9:0]  phase_q, phase_d;
   logic        pol_q, pol_d;      // 1 = negative half of the square wave
   logic [15:0] hold_q, hold_d;
   logic [9:0]  per_q, per_d;
   logic [16:0] amp_q, amp_d;
   logic [17:0] data_q, data_d;

   logic        tick;
   logic        phase_wrap;
   logic [21:0] prod;
   logic [21:0] scaled;
   logic [17:0] sample_val;

   // Sample tick, phase wrap and the signed sample built from pre-edge env/polarity.
   always_comb begin
      tick       = (div_q == DIV_LAST);
      // period 0 behaves like period 1: polarity flips on every tick
      phase_wrap = (per_q == 10'd0) || (phase_q == per_q - 10'd1);
      prod       = 22'(amp_q) * 22'(env_q);
      scaled     = prod >> 4;
      // negating zero yields zero, so no negative-zero can be produced
      sample_val = pol_q ? 18'(-scaled) : 18'(scaled);
   end

   // Next-state logic: divider, envelope FSM, phase and output sample.
   always_comb begin
      div_d   = tick ? 12'd0 : div_q + 12'd1;
      ready_d = tick;
      state_d = state_q;
      env_d   = env_q;
      phase_d = phase_q;
      pol_d   = pol_q;
      hold_d  = hold_q;
      per_d   = per_q;
      amp_d   = amp_q;
      data_d  = data_q;

      if (state_q == IDLE) begin
         if (tick) begin
            data_d = 18'd0;
         end
         if (start) begin
            per_d   = period;
            amp_d   = amplitude;
            phase_d = 10'd0;
            pol_d   = 1'b0;
            env_d   = 5'd0;
            state_d = ATTACK;
         end
      end else if (tick) begin
         data_d = sample_val;
         if (phase_wrap) begin
            phase_d = 10'd0;
            pol_d   = ~pol_q;
         end else begin
            phase_d = phase_q + 10'd1;
         end
         case (state_q)
            ATTACK: begin
               env_d = env_q + 5'd1;
               if (env_q == 5'd15) begin
                  state_d = HOLD;
                  hold_d  = 16'd0;
               end
            end
            HOLD: begin
               if (hold_q == HOLD_LAST) begin
                  state_d = DECAY;
               end else begin
                  hold_d = hold_q + 16'd1;
               end
            end
            DECAY: begin
               env_d = env_q - 5'd1;
               if (env_q == 5'd1) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State registers; reset aborts any burst immediately.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         div_q   <= 12'd0;
         ready_q <= 1'b0;
         env_q   <= 5'd0;
         phase_q <= 10'd0;
         pol_q   <= 1'b0;
         hold_q  <= 16'd0;
         per_q   <= 10'd0;
         amp_q   <= 17'd0;
         data_q  <= 18'd0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         ready_q <= ready_d;
         env_q   <= env_d;
         phase_q <= phase_d;
         pol_q   <= pol_d;
         hold_q  <= hold_d;
         per_q   <= per_d;
         amp_q   <= amp_d;
         data_q  <= data_d;
      end
   end

   assign ready  = ready_q;
   assign a_data = data_q;
   assign busy   = (state_q != IDLE);

endmodule
